// File: rtl/panel_serial_pkg.sv
// Shared types and constants for the front-panel serial bridge.
package panel_serial_pkg;

    localparam int unsigned PANEL_LANES      = 4;
    localparam int unsigned PANEL_CHAIN_BITS = 16;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_SHIFT_LO,
        ST_SHIFT_HI,
        ST_LATCH,
        ST_DONE
    } panel_state_e;

endpackage

// File: rtl/panel_serial_tick.sv
// Phase divider: counts 0..CLK_DIV-1 and flags the last cycle of each phase.
module panel_serial_tick #(
    parameter int unsigned CLK_DIV = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic clear_i,
    output logic phase_end_o
);

    logic [7:0] cnt_q;

    assign phase_end_o = (cnt_q == 8'(CLK_DIV - 1));

    // Wrapping at phase_end restarts the count on every state entry inside a frame.
    always_ff @(posedge clk) begin
        if (reset || clear_i || phase_end_o) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_q + 8'd1;
        end
    end

endmodule

// File: rtl/panel_serial_io.sv
// Front-panel serial bridge: shifts 4 lanes out to 595 chains, reads 4 lanes from 165 chains.
// Define PANEL_SERIAL_FREE_RUN_EN to run frames back to back and ignore start.
module panel_serial_io
    import panel_serial_pkg::*;
#(
    parameter int unsigned CLK_DIV    = 4,
    parameter int unsigned CHAIN_BITS = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [CHAIN_BITS-1:0] out_word_0,
    input  logic [CHAIN_BITS-1:0] out_word_1,
    input  logic [CHAIN_BITS-1:0] out_word_2,
    input  logic [CHAIN_BITS-1:0] out_word_3,
    output logic [CHAIN_BITS-1:0] in_word_0,
    output logic [CHAIN_BITS-1:0] in_word_1,
    output logic [CHAIN_BITS-1:0] in_word_2,
    output logic [CHAIN_BITS-1:0] in_word_3,
    output logic                  in_valid,
    output logic                  busy,
    output logic                  serial_out_srclk,
    output logic                  serial_out_rclk,
    output logic                  serial_out_ser_0,
    output logic                  serial_out_ser_1,
    output logic                  serial_out_ser_2,
    output logic                  serial_out_ser_3,
    output logic                  serial_in_rclk,
    output logic                  serial_in_shldn,
    input  logic                  serial_in_ser_0,
    input  logic                  serial_in_ser_1,
    input  logic                  serial_in_ser_2,
    input  logic                  serial_in_ser_3
);

    localparam int unsigned BW = $clog2(CHAIN_BITS);

    panel_state_e            state_q;
    logic [BW-1:0]           bit_q;
    logic [CHAIN_BITS-1:0]   out_words [PANEL_LANES];
    logic [CHAIN_BITS-1:0]   shadow_q  [PANEL_LANES];
    logic [CHAIN_BITS-1:0]   in_shift_q[PANEL_LANES];
    logic [CHAIN_BITS-1:0]   in_word_q [PANEL_LANES];
    logic [PANEL_LANES-1:0]  ser_q;
    logic [PANEL_LANES-1:0]  ser_in;
    logic                    in_valid_q, busy_q;
    logic                    out_srclk_q, out_rclk_q, in_rclk_q, shldn_q;
    logic                    phase_end, go;

    assign out_words[0] = out_word_0;
    assign out_words[1] = out_word_1;
    assign out_words[2] = out_word_2;
    assign out_words[3] = out_word_3;
    assign ser_in       = {serial_in_ser_3, serial_in_ser_2, serial_in_ser_1, serial_in_ser_0};

`ifdef PANEL_SERIAL_FREE_RUN_EN
    logic unused_start;
    assign unused_start = start;
    assign go           = 1'b1;
`else
    assign go           = start;
`endif

    panel_serial_tick #(.CLK_DIV(CLK_DIV)) u_tick (
        .clk         (clk),
        .reset       (reset),
        .clear_i     ((state_q == ST_IDLE) || (state_q == ST_DONE)),
        .phase_end_o (phase_end)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            bit_q       <= '0;
            ser_q       <= '0;
            in_valid_q  <= 1'b0;
            busy_q      <= 1'b0;
            out_srclk_q <= 1'b0;
            out_rclk_q  <= 1'b0;
            in_rclk_q   <= 1'b0;
            shldn_q     <= 1'b1;
            for (int unsigned n = 0; n < PANEL_LANES; n++) begin
                shadow_q[n]   <= '0;
                in_shift_q[n] <= '0;
                in_word_q[n]  <= '0;
            end
        end else begin
            in_valid_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (go) begin
                        for (int unsigned n = 0; n < PANEL_LANES; n++) shadow_q[n] <= out_words[n];
                        shldn_q <= 1'b0;
                        busy_q  <= 1'b1;
                        state_q <= ST_LOAD;
                    end
                end
                ST_LOAD: begin
                    if (phase_end) begin
                        shldn_q <= 1'b1;
                        bit_q   <= BW'(CHAIN_BITS - 1);
                        for (int unsigned n = 0; n < PANEL_LANES; n++) begin
                            ser_q[n]    <= shadow_q[n][CHAIN_BITS-1];
                            shadow_q[n] <= shadow_q[n] << 1;
                        end
                        state_q <= ST_SHIFT_LO;
                    end
                end
                ST_SHIFT_LO: begin
                    if (phase_end) begin
                        for (int unsigned n = 0; n < PANEL_LANES; n++)
                            in_shift_q[n] <= {in_shift_q[n][CHAIN_BITS-2:0], ser_in[n]};
                        out_srclk_q <= 1'b1;
                        in_rclk_q   <= 1'b1;
                        state_q     <= ST_SHIFT_HI;
                    end
                end
                ST_SHIFT_HI: begin
                    if (phase_end) begin
                        out_srclk_q <= 1'b0;
                        in_rclk_q   <= 1'b0;
                        if (bit_q == '0) begin
                            out_rclk_q <= 1'b1;
                            state_q    <= ST_LATCH;
                        end else begin
                            bit_q <= bit_q - 1'b1;
                            for (int unsigned n = 0; n < PANEL_LANES; n++) begin
                                ser_q[n]    <= shadow_q[n][CHAIN_BITS-1];
                                shadow_q[n] <= shadow_q[n] << 1;
                            end
                            state_q <= ST_SHIFT_LO;
                        end
                    end
                end
                ST_LATCH: begin
                    if (phase_end) begin
                        out_rclk_q <= 1'b0;
                        in_valid_q <= 1'b1;
                        for (int unsigned n = 0; n < PANEL_LANES; n++) in_word_q[n] <= in_shift_q[n];
                        state_q <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    busy_q  <= 1'b0;
                    state_q <= ST_IDLE;
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign in_word_0        = in_word_q[0];
    assign in_word_1        = in_word_q[1];
    assign in_word_2        = in_word_q[2];
    assign in_word_3        = in_word_q[3];
    assign in_valid         = in_valid_q;
    assign busy             = busy_q;
    assign serial_out_srclk = out_srclk_q;
    assign serial_out_rclk  = out_rclk_q;
    assign serial_out_ser_0 = ser_q[0];
    assign serial_out_ser_1 = ser_q[1];
    assign serial_out_ser_2 = ser_q[2];
    assign serial_out_ser_3 = ser_q[3];
    assign serial_in_rclk   = in_rclk_q;
    assign serial_in_shldn  = shldn_q;

endmodule

// File: doc/panel_serial_io.md
# panel_serial_io

SoC-side serial bridge for the front panel. Periodically shifts four 16-bit display words out to four cascaded 74LV595 pairs and, in the same frame, reads four 16-bit switch words from four cascaded 74LV165 pairs. It sits inside `soc_top` between the panel/PU logic and the `serial_out_*` / `serial_in_*` pins. It is the driving end of the chip chains that the simulation top models.

## Interface
Parameters:
- `CLK_DIV`, default 4: `clk` cycles per serial half-phase. Legal range is 1..255.
- `CHAIN_BITS`, default 16: bits per lane, i.e. two chips. This value is fixed.

Ports:
- `clk` in 1: single clock.
- `reset` in 1: synchronous, active-high reset.
- `start` in 1: one-cycle frame request. Ignored while `busy` is high.
- `out_word_0`..`out_word_3` in 16 each: display data per lane. Captured at frame start.
- `in_word_0`..`in_word_3` out 16 each: last completed switch read per lane.
- `in_valid` out 1: one-cycle pulse when the `in_word_*` outputs update.
- `busy` out 1: a frame is in progress.
- `serial_out_srclk`, `serial_out_rclk` out 1 each: 595 shift clock and 595 latch clock.
- `serial_out_ser_0`..`serial_out_ser_3` out 1 each: 595 serial data per lane.
- `serial_in_rclk`, `serial_in_shldn` out 1 each: 165 clock and 165 load (active low).
- `serial_in_ser_0`..`serial_in_ser_3` in 1 each: 165 QH per lane.

## Operation
State machine: IDLE → LOAD → SHIFT_LO ↔ SHIFT_HI (16 bits) → LATCH → DONE → IDLE.
- **IDLE**
  - All serial outputs are at rest: `shldn`=1, both srclk and rclk lines 0, ser lines hold.
  - On `start`, copy `out_word_*` into shadow registers and go to LOAD.
- **LOAD** (CLK_DIV cycles): `serial_in_shldn`=0, which parallel-loads the 165s.
- **SHIFT_LO for bit b** (b = 15 down to 0, MSB first), CLK_DIV cycles:
  - `serial_out_ser_n` = shadow_n[b].
  - `serial_out_srclk`=0 and `serial_in_rclk`=0.
  - In the last cycle, shift `serial_in_ser_n` into the LSB of in_shift_n.
- **SHIFT_HI** (CLK_DIV cycles): `serial_out_srclk`=1 and `serial_in_rclk`=1, producing rising edges on both chains. The ser lines are held stable.
- **LATCH** (CLK_DIV cycles): `serial_out_rclk`=1, which transfers the 595 shift registers to their outputs.
- **DONE** (1 cycle):
  - `in_word_n` ← in_shift_n.
  - `in_valid`=1.
  - Then go to IDLE.
- Resulting bit mapping:
  - 595 pair n ends with Q[15:0] = out_word_n, where the first chip is bits [7:0].
  - in_word_n[15:0] = 165 pair D[15:0], where the chip driving QH holds [15:8].
- Boundary conditions:
  - `start` while busy: dropped, not queued.
  - `out_word_*` changes mid-frame: no effect on the frame in progress.
  - `reset` mid-frame: abort immediately. `serial_out_rclk` is never pulsed, so panel outputs keep the previously latched value.

## Timing
- Reset values:
  - `busy`=0, `in_valid`=0, `in_word_*`=0.
  - `serial_in_shldn`=1.
  - `serial_out_srclk`=0, `serial_out_rclk`=0, `serial_in_rclk`=0.
  - `serial_out_ser_*`=0.
  - State = IDLE, divider = 0.
- For `start` sampled in cycle t:
  - LOAD occupies t+1 .. t+CLK_DIV.
  - Bit b (k = 15−b) is low during t+1+CLK_DIV·(1+2k) for CLK_DIV cycles, then high for CLK_DIV cycles.
  - LATCH occupies t+1+33·CLK_DIV .. t+34·CLK_DIV.
  - `in_valid` and the DONE state occur at t+1+34·CLK_DIV.
- `busy` is high from t+1 through the DONE cycle, inclusive.
- All serial outputs are registered, with no combinational path from inputs.
- The divider counts 0..CLK_DIV−1 within each phase.
- Serial clocks therefore run at f_clk / (2·CLK_DIV).

## Configuration
- `PANEL_SERIAL_FREE_RUN_EN` defined:
  - IDLE lasts exactly one cycle and then starts a frame internally. The `start` port is ignored.
  - The first frame begins the cycle after `reset` deasserts.
  - Frame period is 34·CLK_DIV+2 cycles.
- Not defined: frames run only on `start` pulses.

## Structure
- Package `panel_serial_pkg` holds:
  - the state enum type,
  - `PANEL_LANES`=4,
  - `PANEL_CHAIN_BITS`=16.
- Sub-module `panel_serial_tick`: phase divider with a counter and a `phase_end` output, reset on each state entry.

## Test plan
- **Reset values:** assert `reset` for 3 cycles → all outputs hold their reset values and `busy`=0.
- **Display write:** CLK_DIV=2, out_word_0=16'hA5C3, out_word_3=16'h0F0F, `start` at t → 595 models show A5C3 and 0F0F after t+68; `in_valid` rises at t+69.
- **Switch read:** 165 D inputs lane1=16'h8001, lane2=16'h7FFE → in_word_1=8001 and in_word_2=7FFE at `in_valid`; other lanes read 0.
- **Start while busy:** `start` pulsed at t and t+10 → exactly one `in_valid`, and `busy` falls once.
- **Reset mid-frame:** `reset` asserted during bit 7 of the second frame → rclk never rises, and 595 outputs keep the first frame's data.
- **Free-run:** with `PANEL_SERIAL_FREE_RUN_EN`, CLK_DIV=1 → `in_valid` pulses every 36 cycles, and `start` has no effect.
